// File: rtl/sd_init_ctrl.sv
// sd_init_ctrl: SD SPI-mode sequencer. Runs the card power-up/init sequence
// (CMD0, [CMD8], CMD55/ACMD41 loop, CMD16) and then serves single 32-bit
// CMD17 block reads on request. Every command is guarded by a watchdog.
// Optional feature: define SD_CTRL_CMD8_EN to issue CMD8 (SD v2 cards);
// without it CMD0 success goes straight to CMD55 (SD v1 cards).
module sd_init_ctrl #(
   parameter int unsigned POWERUP_CYCLES = 80,
   parameter int unsigned ACMD41_RETRIES = 255,
   parameter int unsigned CMD_TIMEOUT    = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rd_req,
   input  logic [31:0] rd_addr,
   output logic        rd_ack,
   output logic        rd_err,
   output logic [31:0] rd_data,
   output logic        ready,
   output logic        busy,
   output logic        error,
   output logic [2:0]  err_code,
   output logic        sd_cs_n,
   output logic [7:0]  cmd_number,
   output logic [31:0] cmd_args,
   output logic [7:0]  cmd_crc,
   output logic        cmd_start,
   input  logic        cmd_done,
   input  logic [7:0]  cmd_resp,
   input  logic [31:0] cmd_data
);

   typedef enum logic [3:0] {
      ST_PWRUP,
      ST_CMD0,
`ifdef SD_CTRL_CMD8_EN
      ST_CMD8,
`endif
      ST_CMD55,
      ST_ACMD41,
      ST_CMD16,
      ST_IDLE,
      ST_READ,
      ST_GAP,
      ST_ERROR
   } state_t;

   localparam logic [2:0]  ERR_CMD0   = 3'd1;
`ifdef SD_CTRL_CMD8_EN
   localparam logic [2:0]  ERR_CMD8   = 3'd2;
`endif
   localparam logic [2:0]  ERR_ACMD41 = 3'd3;
   localparam logic [2:0]  ERR_TMO    = 3'd4;
   localparam logic [2:0]  ERR_RESP   = 3'd5;

   localparam logic [15:0] PWR_LAST   = 16'(POWERUP_CYCLES - 1);
   localparam logic [15:0] RETRY_INIT = 16'(ACMD41_RETRIES);
   localparam logic [10:0] WDOG_LAST  = 11'(CMD_TIMEOUT - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   state_t      r_last;
   logic [7:0]  r_resp;
   logic [31:0] r_data;
   logic [15:0] r_pwr_cnt;
   logic [15:0] r_retry;
   logic [10:0] r_wdog;
   logic [2:0]  w_err_nxt;
   logic        w_retry_dec;
   logic        w_read_fin;

   logic        r_rd_ack;
   logic        r_rd_err;
   logic [31:0] r_rd_data;
   logic        r_ready;
   logic        r_busy;
   logic        r_error;
   logic [2:0]  r_err_code;
   logic        r_cs_n;
   logic [7:0]  r_cmd_number;
   logic [31:0] r_cmd_args;
   logic [7:0]  r_cmd_crc;
   logic        r_cmd_start;

   assign rd_ack     = r_rd_ack;
   assign rd_err     = r_rd_err;
   assign rd_data    = r_rd_data;
   assign ready      = r_ready;
   assign busy       = r_busy;
   assign error      = r_error;
   assign err_code   = r_err_code;
   assign sd_cs_n    = r_cs_n;
   assign cmd_number = r_cmd_number;
   assign cmd_args   = r_cmd_args;
   assign cmd_crc    = r_cmd_crc;
   assign cmd_start  = r_cmd_start;

   // States in which a command is being driven to the engine.
   function automatic logic f_is_cmd(input state_t s);
      case (s)
         ST_CMD0, ST_CMD55, ST_ACMD41, ST_CMD16, ST_READ: f_is_cmd = 1'b1;
`ifdef SD_CTRL_CMD8_EN
         ST_CMD8:                                         f_is_cmd = 1'b1;
`endif
         default:                                         f_is_cmd = 1'b0;
      endcase
   endfunction

   assign w_read_fin = (r_state == ST_GAP) && (r_last == ST_READ);

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_PWRUP;
      else       r_state <= w_state_nxt;
   end

   // Next-state decode; response checks happen in GAP on the latched R1.
   always_comb begin
      w_state_nxt = r_state;
      w_err_nxt   = 3'd0;
      w_retry_dec = 1'b0;
      if (f_is_cmd(r_state)) begin
         // cmd_done takes priority over a same-cycle watchdog expiry
         if (cmd_done) begin
            w_state_nxt = ST_GAP;
         end else if (r_wdog >= WDOG_LAST) begin
            w_state_nxt = ST_ERROR;
            w_err_nxt   = ERR_TMO;
         end
      end else begin
         case (r_state)
            ST_PWRUP: if (r_pwr_cnt >= PWR_LAST) w_state_nxt = ST_CMD0;
            ST_IDLE:  if (rd_req) w_state_nxt = ST_READ;
            ST_GAP: begin
               case (r_last)
                  ST_CMD0: begin
                     if (r_resp == 8'h01) begin
`ifdef SD_CTRL_CMD8_EN
                        w_state_nxt = ST_CMD8;
`else
                        w_state_nxt = ST_CMD55;
`endif
                     end else begin
                        w_state_nxt = ST_ERROR;
                        w_err_nxt   = ERR_CMD0;
                     end
                  end
`ifdef SD_CTRL_CMD8_EN
                  ST_CMD8: begin
                     if (r_resp == 8'h01) begin
                        w_state_nxt = ST_CMD55;
                     end else begin
                        w_state_nxt = ST_ERROR;
                        w_err_nxt   = ERR_CMD8;
                     end
                  end
`endif
                  ST_CMD55: begin
                     if ((r_resp == 8'h00) || (r_resp == 8'h01)) begin
                        w_state_nxt = ST_ACMD41;
                     end else begin
                        w_state_nxt = ST_ERROR;
                        w_err_nxt   = ERR_RESP;
                     end
                  end
                  ST_ACMD41: begin
                     if (r_resp == 8'h00) begin
                        w_state_nxt = ST_CMD16;
                     end else if (r_resp == 8'h01) begin
                        // the decrement that would reach zero is the failure
                        if (r_retry <= 16'd1) begin
                           w_state_nxt = ST_ERROR;
                           w_err_nxt   = ERR_ACMD41;
                        end else begin
                           w_retry_dec = 1'b1;
                           w_state_nxt = ST_CMD55;
                        end
                     end else begin
                        w_state_nxt = ST_ERROR;
                        w_err_nxt   = ERR_RESP;
                     end
                  end
                  ST_CMD16: begin
                     if (r_resp == 8'h00) begin
                        w_state_nxt = ST_IDLE;
                     end else begin
                        w_state_nxt = ST_ERROR;
                        w_err_nxt   = ERR_RESP;
                     end
                  end
                  ST_READ: w_state_nxt = ST_IDLE;
                  default: begin
                     w_state_nxt = ST_ERROR;
                     w_err_nxt   = ERR_RESP;
                  end
               endcase
            end
            default: ;
         endcase
      end
   end

   // Registered outputs, derived from the next state, plus datapath latches.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_last       <= ST_PWRUP;
         r_resp       <= '0;
         r_data       <= '0;
         r_pwr_cnt    <= '0;
         r_retry      <= RETRY_INIT;
         r_wdog       <= '0;
         r_rd_ack     <= 1'b0;
         r_rd_err     <= 1'b0;
         r_rd_data    <= '0;
         r_ready      <= 1'b0;
         r_busy       <= 1'b1;
         r_error      <= 1'b0;
         r_err_code   <= '0;
         r_cs_n       <= 1'b1;
         r_cmd_number <= '0;
         r_cmd_args   <= '0;
         r_cmd_crc    <= 8'hFF;
         r_cmd_start  <= 1'b0;
      end else begin
         r_cmd_start <= f_is_cmd(w_state_nxt);
         r_cs_n      <= (w_state_nxt == ST_PWRUP) || (w_state_nxt == ST_ERROR);
         r_busy      <= !((w_state_nxt == ST_IDLE) || (w_state_nxt == ST_ERROR));
         r_ready     <= (w_state_nxt == ST_IDLE);
         r_error     <= (w_state_nxt == ST_ERROR);
         if ((w_state_nxt == ST_ERROR) && (r_state != ST_ERROR))
            r_err_code <= w_err_nxt;

         if (r_state == ST_PWRUP)
            r_pwr_cnt <= r_pwr_cnt + 16'd1;

         // watchdog: saturating count of cycles with cmd_start high
         if (!r_cmd_start)      r_wdog <= '0;
         else if (r_wdog != '1) r_wdog <= r_wdog + 11'd1;

         if (w_retry_dec)
            r_retry <= r_retry - 16'd1;

         if (f_is_cmd(r_state) && cmd_done) begin
            r_last <= r_state;
            r_resp <= cmd_resp;
            r_data <= cmd_data;
         end

         r_rd_ack <= w_read_fin;
         r_rd_err <= w_read_fin && (r_resp != 8'h00);
         if (w_read_fin)
            r_rd_data <= r_data;

         // command fields load on entry; READ takes rd_addr as it is accepted
         if (f_is_cmd(w_state_nxt) && (w_state_nxt != r_state)) begin
            case (w_state_nxt)
               ST_CMD0: begin
                  r_cmd_number <= 8'h40;
                  r_cmd_args   <= 32'h0000_0000;
                  r_cmd_crc    <= 8'h95;
               end
`ifdef SD_CTRL_CMD8_EN
               ST_CMD8: begin
                  r_cmd_number <= 8'h48;
                  r_cmd_args   <= 32'h0000_01AA;
                  r_cmd_crc    <= 8'h87;
               end
`endif
               ST_CMD55: begin
                  r_cmd_number <= 8'h77;
                  r_cmd_args   <= 32'h0000_0000;
                  r_cmd_crc    <= 8'hFF;
               end
               ST_ACMD41: begin
                  r_cmd_number <= 8'h69;
                  r_cmd_args   <= 32'h4000_0000;
                  r_cmd_crc    <= 8'hFF;
               end
               ST_CMD16: begin
                  r_cmd_number <= 8'h50;
                  r_cmd_args   <= 32'h0000_0004;
                  r_cmd_crc    <= 8'hFF;
               end
               ST_READ: begin
                  r_cmd_number <= 8'h51;
                  r_cmd_args   <= rd_addr;
                  r_cmd_crc    <= 8'hFF;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sd_init_ctrl.sv
// tb_sd_init_ctrl: directed bench for sd_init_ctrl with a small command
// engine model that answers each command after a fixed delay.
module tb_sd_init_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        rd_req;
   logic [31:0] rd_addr;
   logic        rd_ack;
   logic        rd_err;
   logic [31:0] rd_data;
   logic        ready;
   logic        busy;
   logic        error;
   logic [2:0]  err_code;
   logic        sd_cs_n;
   logic [7:0]  cmd_number;
   logic [31:0] cmd_args;
   logic [7:0]  cmd_crc;
   logic        cmd_start;
   logic        cmd_done;
   logic [7:0]  cmd_resp;
   logic [31:0] cmd_data;

   int n_checks = 0;
   int n_fail   = 0;

   // engine model configuration (written by the main sequence only)
   logic [7:0]  m_r_cmd0;
   logic [7:0]  m_r_cmd8;
   logic [7:0]  m_r_cmd16;
   logic [7:0]  m_r_cmd17;
   logic [31:0] m_d_cmd17;
   int          m_acmd41_ones;
   logic [7:0]  m_hang_num;

   // engine model counters (written by the model only)
   int m_n_cmd0, m_n_cmd8, m_n_cmd55, m_n_acmd41, m_n_cmd16, m_n_cmd17;
   int m_wait;

`ifdef SD_CTRL_CMD8_EN
   localparam int EXP_CMD8 = 1;
`else
   localparam int EXP_CMD8 = 0;
`endif

   always #5 clk = ~clk;

   sd_init_ctrl #(
      .POWERUP_CYCLES(80),
      .ACMD41_RETRIES(3),
      .CMD_TIMEOUT(1024)
   ) dut (
      .clk(clk), .reset(reset),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_err(rd_err),
      .rd_data(rd_data), .ready(ready), .busy(busy), .error(error),
      .err_code(err_code), .sd_cs_n(sd_cs_n), .cmd_number(cmd_number),
      .cmd_args(cmd_args), .cmd_crc(cmd_crc), .cmd_start(cmd_start),
      .cmd_done(cmd_done), .cmd_resp(cmd_resp), .cmd_data(cmd_data)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Engine model: answers on the third negedge of cmd_start, 1-cycle done.
   initial begin
      cmd_done = 1'b0;
      cmd_resp = 8'hFF;
      cmd_data = '0;
      m_wait = 0;
      m_n_cmd0 = 0; m_n_cmd8 = 0; m_n_cmd55 = 0;
      m_n_acmd41 = 0; m_n_cmd16 = 0; m_n_cmd17 = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            cmd_done = 1'b0;
            m_wait = 0;
            m_n_cmd0 = 0; m_n_cmd8 = 0; m_n_cmd55 = 0;
            m_n_acmd41 = 0; m_n_cmd16 = 0; m_n_cmd17 = 0;
         end else if (cmd_done) begin
            cmd_done = 1'b0;
            m_wait = 0;
         end else if (cmd_start) begin
            if (m_wait == 0) begin
               case (cmd_number)
                  8'h40: m_n_cmd0++;
                  8'h48: m_n_cmd8++;
                  8'h77: m_n_cmd55++;
                  8'h69: m_n_acmd41++;
                  8'h50: m_n_cmd16++;
                  8'h51: m_n_cmd17++;
                  default: ;
               endcase
            end
            m_wait++;
            if (m_wait == 3 && cmd_number != m_hang_num) begin
               case (cmd_number)
                  8'h40: cmd_resp = m_r_cmd0;
                  8'h48: cmd_resp = m_r_cmd8;
                  8'h77: cmd_resp = 8'h01;
                  8'h69: cmd_resp = (m_n_acmd41 <= m_acmd41_ones) ? 8'h01 : 8'h00;
                  8'h50: cmd_resp = m_r_cmd16;
                  8'h51: begin cmd_resp = m_r_cmd17; cmd_data = m_d_cmd17; end
                  default: cmd_resp = 8'hFF;
               endcase
               cmd_done = 1'b1;
            end
         end else begin
            m_wait = 0;
         end
      end
   end

   // Called at a negedge with reset high: release and time the CS-high phase.
   task automatic release_and_check_pwrup(input string tag);
      int n;
      reset = 1'b0;
      n = 0;
      while (sd_cs_n && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_pwrup_len"}, n, 80);
      chk({tag, "_cmd0_start"}, cmd_start, 1'b1);
      chk({tag, "_cmd0_num"}, cmd_number, 8'h40);
      chk({tag, "_cmd0_args"}, cmd_args, 32'h0);
      chk({tag, "_cmd0_crc"}, cmd_crc, 8'h95);
   endtask

   task automatic wait_init;
      int n;
      n = 0;
      while (!(ready || error) && n < 5000) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic run_read(input string tag, input logic [31:0] addr,
                           input logic [31:0] exp_data, input logic exp_err,
                           input logic hold);
      int n;
      @(negedge clk);
      rd_addr = addr;
      rd_req  = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_start"}, cmd_start, 1'b1);
      chk({tag, "_num"}, cmd_number, 8'h51);
      chk({tag, "_args"}, cmd_args, addr);
      chk({tag, "_ready_low"}, ready, 1'b0);
      if (!hold) begin
         @(negedge clk);
         rd_req = 1'b0;
      end
      n = 0;
      while (!cmd_done && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_done_seen"}, cmd_done, 1'b1);
      chk({tag, "_gap_start"}, cmd_start, 1'b0);
      chk({tag, "_gap_ack"}, rd_ack, 1'b0);
      @(posedge clk); #1;
      chk({tag, "_ack"}, rd_ack, 1'b1);
      chk({tag, "_data"}, rd_data, exp_data);
      chk({tag, "_err"}, rd_err, exp_err);
      chk({tag, "_ready_ack"}, ready, 1'b1);
      @(posedge clk); #1;
      chk({tag, "_ack_pulse"}, rd_ack, 1'b0);
      chk({tag, "_data_held"}, rd_data, exp_data);
      chk({tag, "_restart"}, cmd_start, hold);
   endtask

   initial begin
      int n;
      int acks;
      int starts;
      reset = 1'b1;
      rd_req = 1'b0;
      rd_addr = '0;
      m_r_cmd0 = 8'h01; m_r_cmd8 = 8'h01; m_r_cmd16 = 8'h00;
      m_r_cmd17 = 8'h00; m_d_cmd17 = '0;
      m_acmd41_ones = 2;
      m_hang_num = 8'h00;
      repeat (3) @(negedge clk);

      // reset values
      chk("rst_busy", busy, 1'b1);
      chk("rst_cs_n", sd_cs_n, 1'b1);
      chk("rst_ready", ready, 1'b0);
      chk("rst_error", error, 1'b0);
      chk("rst_start", cmd_start, 1'b0);
      chk("rst_ack", rd_ack, 1'b0);
      chk("rst_code", err_code, 3'd0);
      chk("rst_rd_data", rd_data, 32'h0);
      chk("rst_num", cmd_number, 8'h00);
      chk("rst_args", cmd_args, 32'h0);
      chk("rst_crc", cmd_crc, 8'hFF);

      // normal init: ACMD41 answers 0x01 twice then 0x00
      release_and_check_pwrup("init");
      wait_init();
      chk("init_ready", ready, 1'b1);
      chk("init_busy", busy, 1'b0);
      chk("init_error", error, 1'b0);
      chk("init_cs_n", sd_cs_n, 1'b0);
      chk("init_n_cmd8", m_n_cmd8, EXP_CMD8);
      chk("init_n_cmd55", m_n_cmd55, 3);
      chk("init_n_acmd41", m_n_acmd41, 3);
      chk("init_n_cmd16", m_n_cmd16, 1);

      // reads
      m_r_cmd17 = 8'h00; m_d_cmd17 = 32'hDEADBEEF;
      run_read("rd1", 32'h0000_0200, 32'hDEADBEEF, 1'b0, 1'b0);
      m_r_cmd17 = 8'h05; m_d_cmd17 = 32'h12345678;
      run_read("rd2", 32'h00AB_CDEF, 32'h12345678, 1'b1, 1'b1);
      @(negedge clk);
      rd_req = 1'b0;
      m_r_cmd17 = 8'h00; m_d_cmd17 = 32'hCAFEF00D;
      n = 0;
      while (!rd_ack && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("rd3_ack", rd_ack, 1'b1);
      chk("rd3_data", rd_data, 32'hCAFEF00D);
      chk("rd3_err", rd_err, 1'b0);
      chk("rd3_args", cmd_args, 32'h00AB_CDEF);
      chk("rd3_n_cmd17", m_n_cmd17, 3);

      // reset in the middle of a read
      m_hang_num = 8'h51;
      @(negedge clk);
      rd_addr = 32'h0000_0400;
      rd_req = 1'b1;
      @(posedge clk); #1;
      chk("rr_start", cmd_start, 1'b1);
      @(negedge clk);
      rd_req = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rr_start_drop", cmd_start, 1'b0);
      chk("rr_cs_n", sd_cs_n, 1'b1);
      chk("rr_busy", busy, 1'b1);
      m_hang_num = 8'h00;
      repeat (2) @(negedge clk);
      release_and_check_pwrup("rr");
      wait_init();
      chk("rr_ready", ready, 1'b1);
      chk("rr_n_cmd0", m_n_cmd0, 1);

      // watchdog: CMD16 never completes
      @(negedge clk);
      reset = 1'b1;
      m_hang_num = 8'h50;
      repeat (2) @(negedge clk);
      release_and_check_pwrup("wd");
      n = 0;
      while (!(cmd_start && cmd_number == 8'h50) && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      chk("wd_cmd16_seen", cmd_number, 8'h50);
      n = 0;
      while (cmd_start && n < 3000) begin
         n++;
         @(posedge clk); #1;
      end
      chk("wd_len", n, 1024);
      chk("wd_error", error, 1'b1);
      chk("wd_code", err_code, 3'd4);
      chk("wd_cs_n", sd_cs_n, 1'b1);
      chk("wd_busy", busy, 1'b0);
      chk("wd_ready", ready, 1'b0);

      // ACMD41 never leaves idle: retries exhausted
      @(negedge clk);
      reset = 1'b1;
      m_hang_num = 8'h00;
      m_acmd41_ones = 1000;
      repeat (2) @(negedge clk);
      release_and_check_pwrup("ax");
      wait_init();
      chk("ax_error", error, 1'b1);
      chk("ax_code", err_code, 3'd3);
      chk("ax_n_acmd41", m_n_acmd41, 3);
      chk("ax_n_cmd55", m_n_cmd55, 3);
      chk("ax_n_cmd16", m_n_cmd16, 0);

      // CMD0 rejected; later reads are ignored
      @(negedge clk);
      reset = 1'b1;
      m_acmd41_ones = 2;
      m_r_cmd0 = 8'h05;
      repeat (2) @(negedge clk);
      release_and_check_pwrup("c0");
      wait_init();
      chk("c0_error", error, 1'b1);
      chk("c0_code", err_code, 3'd1);
      chk("c0_cs_n", sd_cs_n, 1'b1);
      chk("c0_ready", ready, 1'b0);
      chk("c0_n_cmd55", m_n_cmd55, 0);
      @(negedge clk);
      rd_addr = 32'h0000_0800;
      rd_req = 1'b1;
      acks = 0;
      starts = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (rd_ack) acks++;
         if (cmd_start) starts++;
      end
      rd_req = 1'b0;
      chk("c0_no_ack", acks, 0);
      chk("c0_no_start", starts, 0);
      chk("c0_error_sticky", error, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sd_init_ctrl.md
# sd_init_ctrl

Sequencer for the SD SPI-mode command engine. After reset it runs the card power-up and initialisation sequence (CMD0, CMD8, CMD55/ACMD41 loop, CMD16), then serves single 32-bit block read requests with CMD17. It drives the engine's command number, argument, CRC and level-held start, and checks each R1 response flag byte. It sits between the command engine and the user-side reader (e.g. the asset loader).

## Interface
- POWERUP_CYCLES, 80: clocks with CS deasserted before CMD0.
- ACMD41_RETRIES, 255: maximum CMD55/ACMD41 iterations.
- CMD_TIMEOUT, 1024: clocks allowed from cmd_start rise to cmd_done.

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rd_req  in  1  read request, level; sampled only in IDLE
- rd_addr  in  32  block address; latched on accept
- rd_ack  out  1  one-cycle pulse: read finished
- rd_err  out  1  valid with rd_ack; 1 = R1 for CMD17 nonzero
- rd_data  out  32  read word; held until next rd_ack
- ready  out  1  initialisation complete, in IDLE
- busy  out  1  1 in every state except IDLE and ERROR
- error  out  1  sticky init failure
- err_code  out  3  failure cause (below)
- sd_cs_n  out  1  card chip select, active low
- cmd_number  out  8  command byte, already OR'd with 0x40
- cmd_args  out  32  command argument
- cmd_crc  out  8  CRC byte
- cmd_start  out  1  level start to the engine
- cmd_done  in  1  engine finished
- cmd_resp  in  8  engine R1 flags
- cmd_data  in  32  engine data word

## Operation
States: PWRUP, CMD0, CMD8, CMD55, ACMD41, CMD16, IDLE, READ, GAP, ERROR.

- **PWRUP**: sd_cs_n=1, cmd_start=0. Count POWERUP_CYCLES, then go to CMD0. sd_cs_n=0 in all later states except ERROR.
- **Command states**: drive fields and hold cmd_start=1 until cmd_done=1. Latch cmd_resp, then go to GAP.
  - CMD0: 0x40 / 0x00000000 / 0x95.
  - CMD8: 0x48 / 0x000001AA / 0x87.
  - CMD55: 0x77 / 0 / 0xFF.
  - ACMD41: 0x69 / 0x40000000 / 0xFF.
  - CMD16: 0x50 / 0x00000004 / 0xFF.
  - READ (CMD17): 0x51 / latched rd_addr / 0xFF.
- **GAP**: one cycle with cmd_start=0 so the engine clears. The next state is chosen from the latched response:
  - CMD0: 0x01 goes to CMD8; otherwise ERROR, code 1.
  - CMD8: 0x01 goes to CMD55; otherwise ERROR, code 2.
  - CMD55: 0x00 or 0x01 goes to ACMD41; otherwise ERROR, code 5.
  - ACMD41: 0x00 goes to CMD16. 0x01 decrements the retry counter and goes to CMD55; when the counter reaches 0, ERROR, code 3. Any other value: ERROR, code 5.
  - CMD16: 0x00 goes to IDLE; otherwise ERROR, code 5.
  - READ: rd_data is set from cmd_data; rd_ack pulses with rd_err = (resp != 0x00); next state IDLE.
- **Watchdog**: counts clocks while cmd_start=1. Reaching CMD_TIMEOUT forces cmd_start=0 and goes to ERROR, code 4.
- **IDLE**: ready=1. rd_req=1 latches rd_addr and goes to READ.
- **ERROR**: terminal until reset. error=1, ready=0, sd_cs_n=1. rd_req is ignored.

## Timing
- All outputs are registered.
- Reset values:
  - state PWRUP, busy=1, sd_cs_n=1.
  - ready, error, rd_ack, rd_err, cmd_start = 0.
  - err_code=0, rd_data=0, cmd_number=0, cmd_args=0, cmd_crc=0xFF.
  - retry counter = ACMD41_RETRIES.
- rd_req sampled high in IDLE: cmd_start rises on the next edge.
- cmd_done seen high: cmd_start is 0 on the next edge; GAP lasts exactly one cycle.
- Read latency: rd_ack pulses 2 cycles after the cmd_done edge (done → GAP → ack).
- rd_req held high across rd_ack starts a new read right after returning to IDLE. Minimum spacing is one IDLE cycle.
- ready rises on the cycle IDLE is entered. A rd_req already high is accepted that same cycle.
- cmd_done=1 and watchdog expiry in the same cycle: cmd_done wins.
- Reset asserted mid-command: cmd_start drops asynchronously and the sequence restarts at PWRUP.
- The watchdog count is 11 bits and saturates; it does not wrap.

## Configuration
- SD_CTRL_CMD8_EN defined: CMD8 is issued as above.
- Undefined: CMD0 success goes directly to CMD55 (SD v1 cards), error code 2 is never produced, and the CMD8 state is not synthesised.

## Test plan
- Model answers CMD0=0x01, CMD8=0x01, ACMD41=0x01 twice then 0x00, CMD16=0x00 → exactly 3 CMD55 issues, then ready=1 and busy=0.
- In IDLE, rd_req with rd_addr=0x00000200, model resp 0x00, data 0xDEADBEEF → cmd_args=0x00000200 and cmd_number=0x51; rd_ack pulses 1 cycle with rd_data=0xDEADBEEF and rd_err=0.
- CMD0 response 0x05 → error=1, err_code=1, sd_cs_n=1; later rd_req produces no rd_ack.
- Model never asserts cmd_done on CMD16 → cmd_start drops after 1024 cycles; err_code=4.
- ACMD41 always 0x01 with ACMD41_RETRIES=3 → 3 ACMD41 issues, then err_code=3.
- Reset pulsed during READ → cmd_start=0 immediately; sd_cs_n=1 for 80 cycles; CMD0 is reissued.
